// File: rtl/usr_pkg.sv
// Shared types and next-value function for the universal burst shift register.
// usr_next() is the single definition of every register operation; it works on
// a USR_MAX_W-bit container and treats only the low `width` bits as live.
package usr_pkg;

  localparam int unsigned USR_MAX_W = 64;
  localparam int unsigned USR_IDX_W = $clog2(USR_MAX_W);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } usr_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } usr_state_t;

  // Next register value for one application of `mode`; bits at and above
  // `width` are always returned as zero.
  function automatic logic [USR_MAX_W-1:0] usr_next(
    input usr_mode_t             mode,
    input logic [USR_MAX_W-1:0]  outp,
    input logic                  ser_in_r,
    input logic                  ser_in_l,
    input logic [USR_MAX_W-1:0]  par_in,
    input int unsigned           width
  );
    logic [USR_MAX_W-1:0] mask;
    logic [USR_MAX_W-1:0] cur;
    logic [USR_MAX_W-1:0] res;
    logic [USR_IDX_W-1:0] msb;
    // width == USR_MAX_W shifts the one out entirely, giving an all-ones mask
    mask = (USR_MAX_W'(1) << width) - USR_MAX_W'(1);
    msb  = USR_IDX_W'(width - 1);
    cur  = outp & mask;
    res  = cur;
    case (mode)
      MODE_HOLD: res = cur;
      MODE_SHR: begin
        res      = cur >> 1;
        res[msb] = ser_in_r;
      end
      MODE_SHL: begin
        res    = (cur << 1) & mask;
        res[0] = ser_in_l;
      end
      MODE_LOAD: res = par_in & mask;
      MODE_ROR: begin
        res      = cur >> 1;
        res[msb] = cur[0];
      end
      MODE_ROL: begin
        res    = (cur << 1) & mask;
        res[0] = cur[msb];
      end
      MODE_ASR: begin
        res      = cur >> 1;
        res[msb] = cur[msb];
      end
      MODE_CLR: res = '0;
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/usr_burst_shift.sv
// Universal shift register with a burst controller.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   en, mode        single operation applied per cycle while idle
//   ser_in_r/_l     serial bits entering MSB (right shift) / LSB (left shift)
//   par_in          parallel load data
//   start, count    burst request: repeat `mode` count times (count=0 -> done only)
//   outp            register contents
//   ser_out_r/_l    outp[0] / outp[WIDTH-1], combinational from outp
//   busy, done      burst in progress / one-cycle burst completion pulse
module usr_burst_shift
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] outp,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic             busy,
  output logic             done
);

  usr_state_t       state;
  usr_state_t       state_next;
  usr_mode_t        bmode;
  usr_mode_t        bmode_next;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] remaining_next;
  logic [WIDTH-1:0] outp_next;
  logic             busy_next;
  logic             done_next;
  logic             last_op;
  logic             burst_req;

  assign burst_req = start && (count != '0);
  assign last_op   = (remaining == CNT_W'(1));

  // Controller state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bmode     <= MODE_HOLD;
      remaining <= '0;
    end else begin
      state     <= state_next;
      bmode     <= bmode_next;
      remaining <= remaining_next;
    end
  end

  // Next-state and burst counter
  always_comb begin
    state_next     = state;
    bmode_next     = bmode;
    remaining_next = remaining;
    case (state)
      IDLE: begin
        if (burst_req) begin
          state_next     = BURST;
          bmode_next     = usr_mode_t'(mode);
          remaining_next = count;
        end
      end
      BURST: begin
        remaining_next = remaining - CNT_W'(1);
        if (last_op) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; start outranks en in IDLE
  always_comb begin
    outp_next = outp;
    done_next = 1'b0;
    busy_next = (state_next == BURST);
    case (state)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            done_next = 1'b1;
          end
        end else if (en) begin
          outp_next = WIDTH'(usr_next(usr_mode_t'(mode), USR_MAX_W'(outp), ser_in_r,
                                      ser_in_l, USR_MAX_W'(par_in), WIDTH));
        end
      end
      BURST: begin
        // serial and parallel inputs are sampled live on every burst edge
        outp_next = WIDTH'(usr_next(bmode, USR_MAX_W'(outp), ser_in_r,
                                    ser_in_l, USR_MAX_W'(par_in), WIDTH));
        done_next = last_op;
      end
      default: begin
        outp_next = outp;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outp <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      outp <= outp_next;
      busy <= busy_next;
      done <= done_next;
    end
  end

  assign ser_out_r = outp[0];
  assign ser_out_l = outp[WIDTH-1];

endmodule

// File: tb/tb_usr_burst_shift.sv
// Self-checking bench for usr_burst_shift at WIDTH=8.
module tb_usr_burst_shift;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [2:0]    mode;
  logic          ser_in_r;
  logic          ser_in_l;
  logic [W-1:0]  par_in;
  logic          start;
  logic [CW-1:0] count;
  logic [W-1:0]  outp;
  logic          ser_out_r;
  logic          ser_out_l;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  usr_burst_shift #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .ser_in_r(ser_in_r), .ser_in_l(ser_in_l), .par_in(par_in),
    .start(start), .count(count), .outp(outp),
    .ser_out_r(ser_out_r), .ser_out_l(ser_out_l),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       en;
    logic [2:0] mode;
    logic       sr;
    logic       sl;
    logic [7:0] par;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] outp;
    logic       busy;
    logic       done;
  } exp_t;

  vec_t tbl[15];
  exp_t sbq[$];

  // Independent reference for one operation on an 8-bit register
  function automatic logic [7:0] ref_next(input logic [2:0] m, input logic [7:0] q,
                                          input logic sr, input logic sl,
                                          input logic [7:0] p);
    case (m)
      3'd0:    return q;
      3'd1:    return {sr, q[7:1]};
      3'd2:    return {q[6:0], sl};
      3'd3:    return p;
      3'd4:    return {q[0], q[7:1]};
      3'd5:    return {q[6:0], q[7]};
      3'd6:    return {q[7], q[7:1]};
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic set_in(input logic e, input logic [2:0] m, input logic sr, input logic sl,
                        input logic [7:0] p, input logic st, input logic [7:0] c);
    en = e; mode = m; ser_in_r = sr; ser_in_l = sl; par_in = p; start = st; count = c;
  endtask

  // Queue the expectation, clock once, then pop and compare against the DUT
  task automatic step(input string nm, input logic [7:0] eo, input logic eb, input logic ed);
    exp_t e;
    exp_t x;
    e.name = nm; e.outp = eo; e.busy = eb; e.done = ed;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    chk({x.name, ".outp"}, 32'(outp), 32'(x.outp));
    chk({x.name, ".busy"}, 32'(busy), 32'(x.busy));
    chk({x.name, ".done"}, 32'(done), 32'(x.done));
    chk({x.name, ".ser_out_r"}, 32'(ser_out_r), 32'(x.outp[0]));
    chk({x.name, ".ser_out_l"}, 32'(ser_out_l), 32'(x.outp[7]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] m;
    tbl[0]  = '{"load_a5", 1'b1, 3'd3, 1'b0, 1'b0, 8'hA5, 8'hA5};
    tbl[1]  = '{"ror",     1'b1, 3'd4, 1'b0, 1'b0, 8'h00, 8'hD2};
    tbl[2]  = '{"rol",     1'b1, 3'd5, 1'b0, 1'b0, 8'h00, 8'hA5};
    tbl[3]  = '{"asr",     1'b1, 3'd6, 1'b0, 1'b0, 8'h00, 8'hD2};
    tbl[4]  = '{"clear",   1'b1, 3'd7, 1'b0, 1'b0, 8'hFF, 8'h00};
    tbl[5]  = '{"shr1",    1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 8'h80};
    tbl[6]  = '{"shr2",    1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 8'hC0};
    tbl[7]  = '{"shr3",    1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 8'hE0};
    tbl[8]  = '{"shl1",    1'b1, 3'd2, 1'b0, 1'b1, 8'h00, 8'hC1};
    tbl[9]  = '{"hold",    1'b1, 3'd0, 1'b1, 1'b1, 8'h55, 8'hC1};
    tbl[10] = '{"en_off",  1'b0, 3'd7, 1'b0, 1'b0, 8'h00, 8'hC1};
    tbl[11] = '{"shl0",    1'b1, 3'd2, 1'b1, 1'b0, 8'h00, 8'h82};
    tbl[12] = '{"shr0",    1'b1, 3'd1, 1'b0, 1'b1, 8'h00, 8'h41};
    tbl[13] = '{"load_3c", 1'b1, 3'd3, 1'b0, 1'b0, 8'h3C, 8'h3C};
    tbl[14] = '{"asr_pos", 1'b1, 3'd6, 1'b0, 1'b0, 8'h00, 8'h1E};

    rst = 1'b1;
    set_in(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
    // asynchronous reset between clock edges
    #3 rst = 1'b0;
    #1;
    chk("reset.outp", 32'(outp), 32'h00);
    chk("reset.busy", 32'(busy), 32'h0);
    chk("reset.done", 32'(done), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // single-operation table
    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].en, tbl[i].mode, tbl[i].sr, tbl[i].sl, tbl[i].par, 1'b0, 8'd0);
      step(tbl[i].name, tbl[i].exp, 1'b0, 1'b0);
    end

    // rotate-left burst of 3 from 0x81; mode/en/start changes are ignored while busy
    set_in(1'b1, 3'd3, 1'b0, 1'b0, 8'h81, 1'b0, 8'd0);
    step("ld81", 8'h81, 1'b0, 1'b0);
    set_in(1'b0, 3'd5, 1'b0, 1'b0, 8'h00, 1'b1, 8'd3);
    step("b3.accept", 8'h81, 1'b1, 1'b0);
    set_in(1'b1, 3'd7, 1'b1, 1'b1, 8'hFF, 1'b0, 8'd0);
    step("b3.op1", 8'h03, 1'b1, 1'b0);
    set_in(1'b0, 3'd3, 1'b1, 1'b1, 8'hFF, 1'b1, 8'd7);
    step("b3.op2", 8'h06, 1'b1, 1'b0);
    set_in(1'b1, 3'd7, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
    step("b3.op3", 8'h0C, 1'b0, 1'b1);
    set_in(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
    step("b3.after", 8'h0C, 1'b0, 1'b0);

    // count=0: done only, start outranks en
    set_in(1'b1, 3'd7, 1'b0, 1'b0, 8'h00, 1'b1, 8'd0);
    step("c0.pulse", 8'h0C, 1'b0, 1'b1);
    set_in(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
    step("c0.after", 8'h0C, 1'b0, 1'b0);

    // rotate right x9 on 0x01 wraps past the width
    set_in(1'b1, 3'd3, 1'b0, 1'b0, 8'h01, 1'b0, 8'd0);
    step("ld01", 8'h01, 1'b0, 1'b0);
    set_in(1'b0, 3'd4, 1'b0, 1'b0, 8'h00, 1'b1, 8'd9);
    step("r9.accept", 8'h01, 1'b1, 1'b0);
    set_in(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
    m = 8'h01;
    for (int i = 0; i < 9; i++) begin
      m = ref_next(3'd4, m, 1'b0, 1'b0, 8'h00);
      step("r9.op", m, (i < 8), (i == 8));
    end
    chk("r9.final", 32'(outp), 32'h80);

    // back-to-back: new start accepted in the done cycle (asr x2)
    set_in(1'b0, 3'd6, 1'b0, 1'b0, 8'h00, 1'b1, 8'd2);
    step("b2b.accept", 8'h80, 1'b1, 1'b0);
    set_in(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
    m = 8'h80;
    for (int i = 0; i < 2; i++) begin
      m = ref_next(3'd6, m, 1'b0, 1'b0, 8'h00);
      step("b2b.op", m, (i < 1), (i == 1));
    end
    step("b2b.after", 8'hE0, 1'b0, 1'b0);

    // reset during the 2nd of 5 shift-right operations
    set_in(1'b1, 3'd3, 1'b0, 1'b0, 8'hF0, 1'b0, 8'd0);
    step("ldf0", 8'hF0, 1'b0, 1'b0);
    set_in(1'b0, 3'd1, 1'b1, 1'b0, 8'h00, 1'b1, 8'd5);
    step("rb.accept", 8'hF0, 1'b1, 1'b0);
    set_in(1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0);
    step("rb.op1", 8'hF8, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("rb.rst.outp", 32'(outp), 32'h00);
    chk("rb.rst.busy", 32'(busy), 32'h0);
    chk("rb.rst.done", 32'(done), 32'h0);
    @(posedge clk); #1;
    chk("rb.held.outp", 32'(outp), 32'h00);
    chk("rb.held.busy", 32'(busy), 32'h0);
    rst = 1'b1;
    step("rb.nodone", 8'h00, 1'b0, 1'b0);
    // burst after the aborted one runs normally (load x2, par_in sampled live)
    set_in(1'b0, 3'd3, 1'b0, 1'b0, 8'h5A, 1'b1, 8'd2);
    step("rb2.accept", 8'h00, 1'b1, 1'b0);
    set_in(1'b0, 3'd0, 1'b0, 1'b0, 8'h5A, 1'b0, 8'd0);
    step("rb2.op1", 8'h5A, 1'b1, 1'b0);
    set_in(1'b0, 3'd0, 1'b0, 1'b0, 8'h3C, 1'b0, 8'd0);
    step("rb2.op2", 8'h3C, 1'b0, 1'b1);
    set_in(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
    step("rb2.after", 8'h3C, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usr_burst_shift.md
# usr_burst_shift

Parametrised universal shift register, the successor to our fixed 4-bit shifter. The datapath is WIDTH bits wide. It supports eight operations: hold, logical shift in both directions, rotate in both directions, arithmetic shift right, parallel load and clear. A burst controller repeats the selected operation a programmed number of times without further host intervention. It serves as the serialiser/deserialiser and bit-manipulation stage between the parallel datapath and the serial links.

## Interface

Parameters:
- WIDTH, 8: register width in bits; minimum 2.
- CNT_W, 8: width of the burst count field.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  applies `mode` in IDLE; ignored while busy.
- mode  in  3  operation select (encoding under Operation).
- ser_in_r  in  1  serial bit entering the MSB on shift right.
- ser_in_l  in  1  serial bit entering the LSB on shift left.
- par_in  in  WIDTH  parallel load data.
- start  in  1  burst request, sampled in IDLE only.
- count  in  CNT_W  number of burst operations.
- outp  out  WIDTH  register contents.
- ser_out_r  out  1  outp[0], the bit leaving on a right shift.
- ser_out_l  out  1  outp[WIDTH-1], the bit leaving on a left shift.
- busy  out  1  high while in BURST.
- done  out  1  one-cycle pulse when a burst completes.

## Operation

Mode encoding:
- 000 hold.
- 001 shift right: `{ser_in_r, outp[W-1:1]}`.
- 010 shift left: `{outp[W-2:0], ser_in_l}`.
- 011 parallel load: `par_in`.
- 100 rotate right: `{outp[0], outp[W-1:1]}`.
- 101 rotate left: `{outp[W-2:0], outp[W-1]}`.
- 110 arithmetic shift right: `{outp[W-1], outp[W-1:1]}`.
- 111 clear: 0.

States:
- IDLE:
  - start=1, count≥1 → latch mode into `bmode`, latch count into `remaining`, go to BURST; outp unchanged at this edge.
  - start=1, count=0 → stay in IDLE; outp unchanged; done pulses next cycle.
  - start=0, en=1 → apply mode once per cycle.
  - start=0, en=0 → hold.
  - start takes priority over en.
- BURST:
  - Each edge applies `bmode` and decrements `remaining`.
  - The edge where `remaining` goes 1→0 returns to IDLE and asserts done for the following cycle.
  - en, mode, start and count are ignored.
  - ser_in_r, ser_in_l and par_in are sampled live every burst cycle; this is how serial deserialisation works.
- Burst with load or clear simply repeats the operation (idempotent).
- Rotate bursts with count > WIDTH wrap naturally, with no saturation.
- Reset values (asynchronous, rst=0): outp=0, busy=0, done=0, state=IDLE, remaining=0, bmode=000.
- Reset mid-burst aborts immediately; no done pulse.

## Timing

- Single-op latency: mode applied at edge N with en=1 → outp valid after edge N.
- Burst latency:
  - start at edge N with count=k → operations at edges N+1 … N+k.
  - busy high after edge N through edge N+k.
  - done high for exactly the cycle after edge N+k.
  - The next start is accepted at edge N+k+1, i.e. while done is high. This is legal and yields back-to-back bursts.
- count=0: done high for the cycle after edge N; busy never asserts.
- ser_out_r and ser_out_l are combinational from outp, with no extra register stage.
- busy and done are registered outputs.

## Structure

- Package `usr_pkg`:
  - `usr_mode_t` enum holding the eight encodings.
  - `usr_state_t` enum {IDLE, BURST}.
  - Pure function `usr_next(mode, outp, ser_in_r, ser_in_l, par_in)` returning the next register value. It is shared by the single-op and burst paths so both have identical semantics.
- No sub-module: one register process plus the FSM/counter; target 150–250 lines.

## Test plan

All scenarios use WIDTH=8.

- Reset and modes:
  - Assert rst low mid-cycle → outp=0x00, busy=0, done=0 immediately, without waiting for a clock edge.
  - load 0xA5, then rotate right ×1 → 0xD2.
  - rotate left ×1 → 0xA5.
  - arithmetic shift right → 0xD2.
  - clear → 0x00.
- Shift in: ser_in_r=1, shift right ×3 from 0x00 → 0xE0; ser_out_r follows outp[0] each cycle.
- Burst:
  - load 0x81, start with mode=101 and count=3 → outp 0x03, 0x06, 0x0C on successive edges.
  - busy high for 3 cycles; done high for 1 cycle after the third edge.
  - mode/en toggling during the burst has no effect.
- Boundary cases:
  - count=0 → done pulse, busy stays 0, outp unchanged.
  - count=9 rotate right on 0x01 → 0x80.
  - start asserted during busy is ignored.
  - Back-to-back start on the done cycle is accepted.
- Reset mid-burst: rst low at the 2nd of 5 operations → outp=0, state IDLE, no done pulse; a following start burst runs normally.
